// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencer.
//   state_e     : sequencer FSM states (RUN, STORE, FLUSH, ILOCK)
//   MODE_*      : B-mux addressing-mode encodings
//   pipe_max    : integer maximum, used for elaboration-time sizing
//   cnt_width   : width of the shared STORE/FLUSH down-counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STORE = 2'd1,
      FLUSH = 2'd2,
      ILOCK = 2'd3
   } state_e;

   localparam logic [1:0] MODE_IMM = 2'b00;
   localparam logic [1:0] MODE_DIR = 2'b01;
   localparam logic [1:0] MODE_REG = 2'b10;
   localparam logic [1:0] MODE_FWD = 2'b11;

   function automatic int pipe_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One counter serves both STORE and FLUSH, so it is sized for the longer.
   function automatic int cnt_width(input int store_wait, input int flush_depth);
      return $clog2(pipe_max(store_wait, flush_depth) + 1);
   endfunction

endpackage

// File: rtl/pipe_down_counter.sv
// -----------------------------------------------------------------------------
// pipe_down_counter
// Loadable down-counter with zero flag, shared by the STORE and FLUSH phases.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset (count clears to 0)
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module pipe_down_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Pipeline control unit: store sequencing (stall while RAM writes), branch
// flush of fetch/decode, and A/B operand forwarding selects.
//
// Build option: define PIPE_FWD_EN to enable operand forwarding. Without it,
// forwarding outputs stay neutral and a writeback hit instead stalls the
// pipeline for one cycle through the ILOCK state.
//
// Parameters:
//   STORE_WAIT   cycles RAM needs per write (>= 1)
//   FLUSH_DEPTH  cycles flush is asserted per taken branch (>= 1)
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   store              execute-stage instruction is a store
//   branch_taken       taken-branch pulse (valid while stall=0)
//   src_a_exe/src_b_exe  operand registers at execute
//   dst_wb, wb_valid   writeback destination and its valid
//   mode_in            B-mux addressing mode from decoder
//   mode_out           B-mux select
//   fwd_a              A-mux select, 1 = ALU output
//   stall, flush       pipeline hold / fetch-decode squash
//   ram_wea            RAM write enable
//   ram_addr_sel       1 = write address
//   busy               sequencer is not in RUN
// -----------------------------------------------------------------------------
module pipeline_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int STORE_WAIT  = 2,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       store,
   input  logic       branch_taken,
   input  logic [4:0] src_a_exe,
   input  logic [4:0] src_b_exe,
   input  logic [4:0] dst_wb,
   input  logic       wb_valid,
   input  logic [1:0] mode_in,
   output logic [1:0] mode_out,
   output logic       fwd_a,
   output logic       stall,
   output logic       flush,
   output logic       ram_wea,
   output logic       ram_addr_sel,
   output logic       busy
);

   localparam int CNT_W = cnt_width(STORE_WAIT, FLUSH_DEPTH);

   // Entry from RUN spends one phase cycle in RUN itself, hence the -2;
   // entry from STORE starts a full-length flush, hence the -1.
   localparam logic [CNT_W-1:0] STORE_LD     = CNT_W'((STORE_WAIT  > 1) ? STORE_WAIT  - 2 : 0);
   localparam logic [CNT_W-1:0] FLUSH_LD_RUN = CNT_W'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);
   localparam logic [CNT_W-1:0] FLUSH_LD_PND = CNT_W'(FLUSH_DEPTH - 1);

   state_e           state_q, state_d;
   logic             br_pend_q, br_pend_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;

   logic hit_a, hit_b;
   logic ilock_req;

   assign hit_a = wb_valid && (dst_wb == src_a_exe);
   assign hit_b = wb_valid && (dst_wb == src_b_exe);

   // ---------------------------------------------------------------- forwarding
`ifdef PIPE_FWD_EN
   assign mode_out  = (hit_b && (mode_in == MODE_REG)) ? MODE_FWD : mode_in;
   assign fwd_a     = hit_a;
   assign ilock_req = 1'b0;
`else
   assign mode_out  = mode_in;
   assign fwd_a     = 1'b0;
   assign ilock_req = hit_a || hit_b;
`endif

   // ---------------------------------------------------------------- counter
   pipe_down_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         br_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         br_pend_q <= br_pend_d;
      end
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      br_pend_d    = br_pend_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      case (state_q)
         // ILOCK behaves like RUN for store/branch but never re-triggers
         // the interlock, which bounds the interlock stall to one cycle.
         RUN, ILOCK: begin
            state_d = RUN;
            if (store) begin
               if (STORE_WAIT > 1) begin
                  state_d      = STORE;
                  cnt_load     = 1'b1;
                  cnt_load_val = STORE_LD;
                  br_pend_d    = branch_taken;
               end else if (branch_taken) begin
                  // Single-cycle store: no STORE phase to carry br_pend,
                  // so start the full-length flush directly.
                  state_d      = FLUSH;
                  cnt_load     = 1'b1;
                  cnt_load_val = FLUSH_LD_PND;
               end
            end else if (branch_taken) begin
               if (FLUSH_DEPTH > 1) begin
                  state_d      = FLUSH;
                  cnt_load     = 1'b1;
                  cnt_load_val = FLUSH_LD_RUN;
               end
            end else if ((state_q == RUN) && ilock_req) begin
               state_d = ILOCK;
            end
         end

         STORE: begin
            if (cnt_zero) begin
               if (br_pend_q) begin
                  state_d      = FLUSH;
                  cnt_load     = 1'b1;
                  cnt_load_val = FLUSH_LD_PND;
                  br_pend_d    = 1'b0;
               end else begin
                  state_d = RUN;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end

         FLUSH: begin
            // branch_taken is ignored: squashed instructions cannot branch.
            if (cnt_zero) begin
               state_d = RUN;
            end else begin
               cnt_dec = 1'b1;
            end
         end

         default: state_d = RUN;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      stall        = 1'b0;
      flush        = 1'b0;
      ram_wea      = 1'b0;
      ram_addr_sel = 1'b0;

      case (state_q)
         RUN, ILOCK: begin
            stall        = store ||
                           ((state_q == RUN) && ilock_req && !branch_taken);
            ram_wea      = store;
            ram_addr_sel = store;
            flush        = branch_taken && !store;
         end
         STORE: begin
            stall        = 1'b1;
            ram_wea      = 1'b1;
            ram_addr_sel = 1'b1;
         end
         FLUSH: begin
            flush = 1'b1;
         end
         default: ;
      endcase
   end

   // state_q is a register, so busy lags the first stall/flush cycle by one.
   assign busy = (state_q != RUN);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
// Directed bench for pipeline_sequencer. Two instances share all inputs:
//   u_dut  : STORE_WAIT=3, FLUSH_DEPTH=2
//   u_dut2 : STORE_WAIT=2, FLUSH_DEPTH=2
// Control outputs are compared as {stall, flush, ram_wea, ram_addr_sel, busy}.
// Expectations follow the PIPE_FWD_EN build setting.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       store;
   logic       branch_taken;
   logic [4:0] src_a_exe;
   logic [4:0] src_b_exe;
   logic [4:0] dst_wb;
   logic       wb_valid;
   logic [1:0] mode_in;

   logic [1:0] mode_out1, mode_out2;
   logic       fwd_a1, fwd_a2;
   logic       stall1, flush1, wea1, addr1, busy1;
   logic       stall2, flush2, wea2, addr2, busy2;

   logic [4:0] o1, o2;
   assign o1 = {stall1, flush1, wea1, addr1, busy1};
   assign o2 = {stall2, flush2, wea2, addr2, busy2};

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipeline_sequencer #(.STORE_WAIT(3), .FLUSH_DEPTH(2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .store        (store),
      .branch_taken (branch_taken),
      .src_a_exe    (src_a_exe),
      .src_b_exe    (src_b_exe),
      .dst_wb       (dst_wb),
      .wb_valid     (wb_valid),
      .mode_in      (mode_in),
      .mode_out     (mode_out1),
      .fwd_a        (fwd_a1),
      .stall        (stall1),
      .flush        (flush1),
      .ram_wea      (wea1),
      .ram_addr_sel (addr1),
      .busy         (busy1)
   );

   pipeline_sequencer #(.STORE_WAIT(2), .FLUSH_DEPTH(2)) u_dut2 (
      .clk          (clk),
      .rst          (rst),
      .store        (store),
      .branch_taken (branch_taken),
      .src_a_exe    (src_a_exe),
      .src_b_exe    (src_b_exe),
      .dst_wb       (dst_wb),
      .wb_valid     (wb_valid),
      .mode_in      (mode_in),
      .mode_out     (mode_out2),
      .fwd_a        (fwd_a2),
      .stall        (stall2),
      .flush        (flush2),
      .ram_wea      (wea2),
      .ram_addr_sel (addr2),
      .busy         (busy2)
   );

   task automatic check(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive point: just after a rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      store        = 1'b0;
      branch_taken = 1'b0;
      src_a_exe    = 5'd0;
      src_b_exe    = 5'd0;
      dst_wb       = 5'd0;
      wb_valid     = 1'b0;
      mode_in      = 2'b01;

      // ---------------- reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctl",   o1,        5'b00000);
      check("rst_mode",  mode_out1, 2'b01);
      check("rst_fwd_a", fwd_a1,    1'b0);
      rst     = 1'b0;
      mode_in = 2'b00;
      next_cycle();

      // ---------------- single store: 3 stall cycles (dut), 2 (dut2)
      store = 1'b1;
      @(negedge clk);
      check("st_c0",   o1, 5'b10110);
      check("st2_c0",  o2, 5'b10110);
      next_cycle();
      store = 1'b0;
      @(negedge clk);
      check("st_c1",   o1, 5'b10111);
      check("st2_c1",  o2, 5'b10111);
      next_cycle();
      @(negedge clk);
      check("st_c2",   o1, 5'b10111);
      check("st2_c2",  o2, 5'b00000);
      next_cycle();
      @(negedge clk);
      check("st_c3",   o1, 5'b00000);
      next_cycle();

      // ---------------- branch: 2 flush cycles, stall stays 0; branch ignored in FLUSH
      branch_taken = 1'b1;
      @(negedge clk);
      check("br_c0",  o1, 5'b01000);
      check("br2_c0", o2, 5'b01000);
      next_cycle();
      @(negedge clk);
      check("br_c1",  o1, 5'b01001);
      next_cycle();
      branch_taken = 1'b0;
      @(negedge clk);
      check("br_c2",  o1, 5'b00000);
      check("br2_c2", o2, 5'b00000);
      next_cycle();

      // ---------------- store + branch together
      store        = 1'b1;
      branch_taken = 1'b1;
      @(negedge clk);
      check("sb_c0",  o1, 5'b10110);
      check("sb2_c0", o2, 5'b10110);
      next_cycle();
      store        = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      check("sb_c1",  o1, 5'b10111);
      check("sb2_c1", o2, 5'b10111);
      next_cycle();
      @(negedge clk);
      check("sb_c2",  o1, 5'b10111);
      check("sb2_c2", o2, 5'b01001);
      next_cycle();
      @(negedge clk);
      check("sb_c3",  o1, 5'b01001);
      check("sb2_c3", o2, 5'b01001);
      next_cycle();
      @(negedge clk);
      check("sb_c4",  o1, 5'b01001);
      check("sb2_c4", o2, 5'b00000);
      next_cycle();
      @(negedge clk);
      check("sb_c5",  o1, 5'b00000);
      next_cycle();

      // ---------------- reset mid-STORE with a pending branch
      store        = 1'b1;
      branch_taken = 1'b1;
      @(negedge clk);
      check("rs_c0", o1, 5'b10110);
      next_cycle();
      store        = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      check("rs_c1", o1, 5'b10111);
      #2 rst = 1'b1;
      #1;
      check("rs_async",  o1, 5'b00000);
      check("rs2_async", o2, 5'b00000);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("rs_after%0d", i), o1, 5'b00000);
      end
      next_cycle();

      // ---------------- forwarding / interlock
      wb_valid  = 1'b1;
      dst_wb    = 5'd5;
      src_b_exe = 5'd5;
      src_a_exe = 5'd9;
      mode_in   = 2'b10;
      @(negedge clk);
      check("fw_e0_mode", mode_out1, FWD ? 2'b11 : 2'b10);
      check("fw_e0_fa",   fwd_a1,    1'b0);
      check("fw_e0_ctl",  o1,        FWD ? 5'b00000 : 5'b10000);
      next_cycle();
      @(negedge clk);
      check("fw_e1_mode", mode_out1, FWD ? 2'b11 : 2'b10);
      check("fw_e1_ctl",  o1,        FWD ? 5'b00000 : 5'b00001);
      next_cycle();
      mode_in = 2'b00;
      @(negedge clk);
      check("fw_e2_mode", mode_out1, 2'b00);
      check("fw_e2_ctl",  o1,        FWD ? 5'b00000 : 5'b10000);
      next_cycle();
      wb_valid = 1'b0;
      mode_in  = 2'b10;
      @(negedge clk);
      check("fw_e3_mode", mode_out1, 2'b10);
      check("fw_e3_ctl",  o1,        FWD ? 5'b00000 : 5'b00001);
      next_cycle();
      wb_valid  = 1'b1;
      src_a_exe = 5'd5;
      src_b_exe = 5'd9;
      mode_in   = 2'b01;
      @(negedge clk);
      check("fw_e4_fa",   fwd_a1,    FWD ? 1'b1 : 1'b0);
      check("fw_e4_mode", mode_out1, 2'b01);
      check("fw_e4_ctl",  o1,        FWD ? 5'b00000 : 5'b10000);
      next_cycle();
      dst_wb    = 5'd0;
      src_a_exe = 5'd0;
      mode_in   = 2'b10;
      @(negedge clk);
      check("fw_e5_fa",   fwd_a1,    FWD ? 1'b1 : 1'b0);
      check("fw_e5_mode", mode_out1, 2'b10);
      check("fw_e5_ctl",  o1,        FWD ? 5'b00000 : 5'b00001);
      next_cycle();
      @(negedge clk);
      check("fw_e6_r0",   o1,        FWD ? 5'b00000 : 5'b10000);
      next_cycle();
      wb_valid = 1'b0;
      @(negedge clk);
      check("fw_e7_fa",   fwd_a1,    1'b0);
      check("fw_e7_ctl",  o1,        FWD ? 5'b00000 : 5'b00001);
      next_cycle();
      @(negedge clk);
      check("fw_e8_ctl",  o1,        5'b00000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
